// File: rtl/axi_mem_responder_pkg.sv
// Shared definitions for the AXI memory responder.
//   RESP_*  : AXI response codes (B and R channels)
//   BURST_* : AXI burst type encodings
//   w_state_e / r_state_e : write and read FSM states
//   burst_illegal() : flags bursts answered with SLVERR regardless of address
package axi_mem_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam int DATA_WIDTH = 64;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  // Bus is 64 bits wide, so anything wider than 8 bytes per beat is unsupported.
  function automatic logic burst_illegal(input logic [2:0] size,
                                         input logic [7:0] len,
                                         input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'd3) || (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_mem_responder_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for one AXI burst.
//   addr      : address of the current beat
//   size      : log2 bytes per beat
//   len       : beats in burst minus one (sets the WRAP window)
//   burst     : FIXED / INCR / WRAP (reserved code treated as INCR)
//   next_addr : address of the following beat
module axi_burst_addr_gen
  import axi_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    // Window is (len+1) beats; for legal wrap lengths this is a power of two,
    // so the low bits wrap while the high bits stay pinned to the window base.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave backed by a MEM_BYTES on-chip memory (64-bit wide).
// Independent write and read FSMs, one transaction outstanding on each.
//   uncoreclk / uncore_rstn : clock, async active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b* : write address, data, response channels
//   s_axi_ar* / s_axi_r*            : read address and data channels
//   lock/cache/prot/qos inputs are accepted and ignored.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write address
// W_DATA  | wready high, accepting beats until WLAST
// W_RESP  | bvalid high, waiting for bready
// R_IDLE  | arready high, waiting for a read address
// R_FETCH | first beat being read from memory
// R_DATA  | rvalid high, streaming beats until the last one is taken
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_BYTES  = 65536,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  uncoreclk,
  input  logic                  uncore_rstn,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [63:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int MEM_AW    = $clog2(MEM_BYTES);
  localparam int MEM_WORDS = MEM_BYTES / 8;

  // BASE_ADDR is MEM_BYTES aligned, so a hit is just an upper-bit match.
  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:MEM_AW] == BASE_ADDR[ADDR_WIDTH-1:MEM_AW];
  endfunction

  logic [63:0] mem [MEM_WORDS];

  // ---------------- write path ----------------
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_next_addr;
  logic [7:0]            w_len_q, w_beat_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_illegal_q, w_dec_q, w_over_q;
  logic                  w_hs, w_hit, w_we, w_dec_now, w_proto_err;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
    .addr      (w_addr_q),
    .size      (w_size_q),
    .len       (w_len_q),
    .burst     (w_burst_q),
    .next_addr (w_next_addr)
  );

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) w_state_q <= W_IDLE;
    else              w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d     = w_state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_state_d = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && s_axi_wlast) w_state_d = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign w_hit     = addr_hit(w_addr_q);
  // Beats past awlen (w_over_q) are absorbed without touching memory.
  assign w_we      = w_hs && !w_over_q && w_hit && !w_illegal_q;
  assign w_dec_now = w_dec_q || (!w_over_q && !w_hit);
  // WLAST anywhere other than beat awlen is a protocol error.
  assign w_proto_err = w_over_q || (w_beat_q != w_len_q);

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      w_addr_q    <= '0;
      w_len_q     <= '0;
      w_size_q    <= '0;
      w_burst_q   <= BURST_FIXED;
      w_beat_q    <= '0;
      w_illegal_q <= 1'b0;
      w_dec_q     <= 1'b0;
      w_over_q    <= 1'b0;
      s_axi_bid   <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        w_addr_q    <= s_axi_awaddr;
        w_len_q     <= s_axi_awlen;
        w_size_q    <= s_axi_awsize;
        w_burst_q   <= s_axi_awburst;
        w_beat_q    <= '0;
        w_illegal_q <= burst_illegal(s_axi_awsize, s_axi_awlen, s_axi_awburst);
        w_dec_q     <= 1'b0;
        w_over_q    <= 1'b0;
        s_axi_bid   <= s_axi_awid;
      end
      if (w_hs) begin
        w_dec_q <= w_dec_now;
        if (s_axi_wlast) begin
          if (w_dec_now)                       s_axi_bresp <= RESP_DECERR;
          else if (w_illegal_q || w_proto_err) s_axi_bresp <= RESP_SLVERR;
          else                                 s_axi_bresp <= RESP_OKAY;
        end else if (w_beat_q == w_len_q) begin
          w_over_q <= 1'b1;
        end else begin
          w_beat_q <= w_beat_q + 8'd1;
          w_addr_q <= w_next_addr;
        end
      end
    end
  end

  // Backing store is deliberately outside the reset domain.
  always_ff @(posedge uncoreclk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[w_addr_q[MEM_AW-1:3]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_next_addr, r_fetch_addr;
  logic [7:0]            r_len_q, r_beat_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q;
  logic                  r_illegal_q;
  logic                  r_hs, r_load, r_fetch_last;
  logic [1:0]            r_fetch_resp;
  logic [63:0]           mem_rd;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
    .addr      (r_addr_q),
    .size      (r_size_q),
    .len       (r_len_q),
    .burst     (r_burst_q),
    .next_addr (r_next_addr)
  );

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) r_state_q <= R_IDLE;
    else              r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d     = r_state_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) r_state_d = R_FETCH;
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && s_axi_rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign r_hs = s_axi_rvalid && s_axi_rready;
  // The output register is refilled from memory either on entry from FETCH or
  // as the current beat is taken, which keeps beats back-to-back and holds
  // the payload steady while stalled. Reads sample memory before a same-edge
  // write lands, so a colliding write returns old data.
  assign r_fetch_addr = (r_state_q == R_FETCH) ? r_addr_q : r_next_addr;
  assign r_load       = (r_state_q == R_FETCH) || (r_hs && !s_axi_rlast);
  assign r_fetch_last = (r_state_q == R_FETCH) ? (r_len_q == 8'd0)
                                               : ((r_beat_q + 8'd1) == r_len_q);
  assign mem_rd       = mem[r_fetch_addr[MEM_AW-1:3]];

  always_comb begin
    if (!addr_hit(r_fetch_addr)) r_fetch_resp = RESP_DECERR;
    else if (r_illegal_q)        r_fetch_resp = RESP_SLVERR;
    else                         r_fetch_resp = RESP_OKAY;
  end

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      r_addr_q    <= '0;
      r_len_q     <= '0;
      r_size_q    <= '0;
      r_burst_q   <= BURST_FIXED;
      r_beat_q    <= '0;
      r_illegal_q <= 1'b0;
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rlast <= 1'b0;
    end else begin
      if (s_axi_arvalid && s_axi_arready) begin
        r_addr_q    <= s_axi_araddr;
        r_len_q     <= s_axi_arlen;
        r_size_q    <= s_axi_arsize;
        r_burst_q   <= s_axi_arburst;
        r_beat_q    <= '0;
        r_illegal_q <= burst_illegal(s_axi_arsize, s_axi_arlen, s_axi_arburst);
        s_axi_rid   <= s_axi_arid;
      end
      if (r_load) begin
        s_axi_rdata <= (r_fetch_resp == RESP_OKAY) ? mem_rd : 64'd0;
        s_axi_rresp <= r_fetch_resp;
        s_axi_rlast <= r_fetch_last;
      end
      if (r_hs) begin
        if (s_axi_rlast) begin
          s_axi_rlast <= 1'b0;
        end else begin
          r_addr_q <= r_next_addr;
          r_beat_q <= r_beat_q + 8'd1;
        end
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                           w_addr_q[2:0], r_fetch_addr[2:0]};

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  localparam int          AW     = 32;
  localparam int          IW     = 4;
  localparam int          MB     = 65536;
  localparam logic [31:0] BASE   = 32'h0;
  localparam int          REGION = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] awid = '0, arid = '0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic [1:0]    awburst = '0, arburst = '0;
  logic          awvalid = 1'b0, arvalid = 1'b0;
  logic          awready, arready;
  logic [63:0]   wdata = '0;
  logic [7:0]    wstrb = '0;
  logic          wlast = 1'b0, wvalid = 1'b0, wready;
  logic [IW-1:0] bid, rid;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready = 1'b0;
  logic [63:0]   rdata;
  logic          rlast, rvalid, rready = 1'b0;

  always #5 clk = ~clk;

  axi_mem_responder #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_BYTES(MB), .BASE_ADDR(BASE)) dut (
    .uncoreclk(clk), .uncore_rstn(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0), .s_axi_awprot(3'h0),
    .s_axi_awqos(4'h0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h0), .s_axi_arprot(3'h0),
    .s_axi_arqos(4'h0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  // Reference model: byte-addressed image of the low REGION bytes.
  logic [7:0] model [REGION];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic in_map(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(MB));
  endfunction

  function automatic logic is_illegal(input int size, input int len, input logic [1:0] burst);
    return (size > 3) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                            input int len, input logic [1:0] burst, input int i);
    int unsigned step, window, base;
    step   = 1 << size;
    window = (len + 1) * step;
    if (burst == 2'b00) return start;
    if (burst == 2'b10) begin
      base = start - (start % window);
      return base + ((start - base + i * step) % window);
    end
    return start + i * step;
  endfunction

  function automatic logic [63:0] model_word(input logic [31:0] a);
    logic [63:0] w;
    int unsigned base;
    base = a & ~32'h7;
    w = '0;
    if (base + 7 < REGION)
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = model[base + b];
    return w;
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input int nbeats,
                           input int strb_sel, input logic data_fixed, input logic [63:0] data_val);
    int n;
    logic hs, ill, any_dec;
    logic [31:0] a;
    logic [1:0] exp_resp, got_resp;
    logic [3:0] got_id;
    ill = is_illegal(size, len, burst);
    any_dec = 1'b0;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = burst; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); hs = awready; @(posedge clk); #1; n++; end while (!hs && n < 50);
    awvalid = 1'b0;
    if (!hs) chk("aw_timeout", 0, 1);
    for (int i = 0; i < nbeats; i++) begin
      wdata = data_fixed ? data_val : {$urandom, $urandom};
      wstrb = (strb_sel < 0) ? 8'($urandom) : 8'(strb_sel);
      wlast = (i == nbeats - 1);
      wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); hs = wready; @(posedge clk); #1; n++; end while (!hs && n < 50);
      if (!hs) chk("w_timeout", 0, 1);
      if (i <= len) begin
        a = beat_addr(addr, size, len, burst, i);
        if (!in_map(a)) any_dec = 1'b1;
        else if (!ill)
          for (int b = 0; b < 8; b++)
            if (wstrb[b] && ((a & ~32'h7) + b < REGION)) model[(a & ~32'h7) + b] = wdata[b*8 +: 8];
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (any_dec) exp_resp = RESP_DECERR;
    else if (ill || nbeats != len + 1) exp_resp = RESP_SLVERR;
    else exp_resp = RESP_OKAY;
    @(negedge clk);
    chk("bvalid_after_wlast", 64'(bvalid), 1);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) chk("b_timeout", 0, 1);
    got_resp = bresp; got_id = bid;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bresp", 64'(got_resp), 64'(exp_resp));
    chk("bid", 64'(got_id), 64'(id));
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst, input logic rand_ready,
                          input int abort_after, output logic [63:0] d0, output logic [1:0] r0);
    int n, lat, beat, guard;
    logic hs, ill, held;
    logic [31:0] a;
    logic [63:0] exp_d [16];
    logic [1:0]  exp_r [16];
    logic [63:0] hold_d;
    logic [6:0]  hold_m;
    ill = is_illegal(size, len, burst);
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, size, len, burst, i);
      exp_r[i] = !in_map(a) ? RESP_DECERR : (ill ? RESP_SLVERR : RESP_OKAY);
      exp_d[i] = (exp_r[i] == RESP_OKAY) ? model_word(a) : 64'd0;
    end
    d0 = '0; r0 = '0;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = burst; arvalid = 1'b1;
    rready = rand_ready ? 1'($urandom) : 1'b1;
    n = 0;
    do begin @(negedge clk); hs = arready; @(posedge clk); #1; n++; end while (!hs && n < 50);
    arvalid = 1'b0;
    if (!hs) chk("ar_timeout", 0, 1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid && lat < 50);
    chk("r_first_latency", 64'(lat), 2);
    beat = 0; guard = 0; held = 1'b0; hold_d = '0; hold_m = '0;
    while (beat <= len && guard < 400) begin
      if (abort_after >= 0 && beat == abort_after) break;
      if (rvalid) begin
        if (held) begin
          chk("r_hold_data", rdata, hold_d);
          chk("r_hold_ctl", 64'({rid, rresp, rlast}), 64'(hold_m));
        end
        if (rready) begin
          chk("rdata", rdata, exp_d[beat]);
          chk("rresp", 64'(rresp), 64'(exp_r[beat]));
          chk("rlast", 64'(rlast), 64'(beat == len));
          chk("rid", 64'(rid), 64'(id));
          if (beat == 0) begin d0 = rdata; r0 = rresp; end
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1; hold_d = rdata; hold_m = {rid, rresp, rlast};
        end
      end
      @(posedge clk); #1;
      rready = rand_ready ? 1'($urandom) : 1'b1;
      @(negedge clk);
      guard++;
    end
    if (abort_after < 0) begin
      if (beat <= len) chk("r_timeout", 0, 1);
      chk("r_idle_after_last", 64'({rvalid, arready}), 64'(2'b01));
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d0;
    logic [1:0]  r0;
    for (int i = 0; i < REGION; i++) model[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'({awready, arready, wready, bvalid, rvalid, rlast}), 64'(6'b110000));
    chk("rst_ids", 64'({bid, rid, bresp, rresp}), 0);
    chk("rst_rdata", rdata, 0);

    // Fill the working region so every later read has defined contents.
    for (int k = 0; k < REGION / 128; k++)
      axi_write(4'(k), 32'(k * 128), 15, 3, BURST_INCR, 16, 8'hFF, 1'b0, 64'd0);

    // Basic INCR write then read-back, back-to-back beats.
    axi_write(4'h5, 32'h100, 3, 3, BURST_INCR, 4, 8'hFF, 1'b0, 64'd0);
    axi_read(4'h6, 32'h100, 3, 3, BURST_INCR, 1'b0, -1, d0, r0);

    // WRAP beat order 0x118,0x100,0x108,0x110.
    axi_read(4'h7, 32'h118, 3, 3, BURST_WRAP, 1'b0, -1, d0, r0);
    chk("wrap_first_beat", d0, model_word(32'h118));

    // Partial strobes.
    axi_write(4'h1, 32'h0, 0, 3, BURST_INCR, 1, 8'hFF, 1'b1, 64'd0);
    axi_write(4'h1, 32'h0, 0, 3, BURST_INCR, 1, 8'h0F, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    axi_read(4'h2, 32'h0, 0, 3, BURST_INCR, 1'b0, -1, d0, r0);
    chk("strb_readback", d0, 64'h0000_0000_FFFF_FFFF);

    // Just past the decoded range.
    axi_read(4'h3, BASE + 32'(MB), 0, 3, BURST_INCR, 1'b0, -1, d0, r0);
    chk("decerr_resp", 64'(r0), 64'(2'b11));
    chk("decerr_data", d0, 0);

    // Extra beat after awlen: dropped, SLVERR.
    axi_write(4'h9, 32'h200, 1, 3, BURST_INCR, 3, 8'hFF, 1'b1, 64'hA5A5_5A5A_1234_5678);
    axi_read(4'hA, 32'h200, 2, 3, BURST_INCR, 1'b1, -1, d0, r0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int size, len, span, step;
      logic [1:0] burst;
      logic [31:0] addr;
      burst = 2'($urandom_range(0, 2));
      size  = $urandom_range(0, 3);
      if (burst == BURST_WRAP) begin
        len = (1 << $urandom_range(1, 4)) - 1;
      end else begin
        len = $urandom_range(0, 7);
      end
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) size = 4;
        else begin burst = 2'b11; len = $urandom_range(0, 7); end
      end
      step = 1 << size;
      span = (len + 1) * step;
      addr = 32'($urandom_range(0, (REGION - span) / step) * step);
      if ($urandom_range(0, 1) == 1)
        axi_write(4'($urandom), addr, len, size, burst, len + 1, -1, 1'b0, 64'd0);
      else
        axi_read(4'($urandom), addr, len, size, burst, 1'b1, -1, d0, r0);
    end

    // Stalled len=7 read, then reset in the middle of it.
    axi_read(4'hC, 32'h300, 7, 3, BURST_INCR, 1'b1, 3, d0, r0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 64'(rvalid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'({awready, arready, wready, bvalid, rvalid, rlast}), 64'(6'b110000));
    chk("post_rst_payload", rdata, 0);
    chk("post_rst_ids", 64'({bid, rid, bresp, rresp}), 0);
    // Memory contents survive reset.
    axi_read(4'hD, 32'h300, 15, 3, BURST_INCR, 1'b1, -1, d0, r0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-003 SHALL have parameter MEM_BYTES, default 65536, backing-store size in bytes; power of two, ≥ 8.
REQ-004 SHALL have parameter BASE_ADDR, default 0, first decoded byte address; MEM_BYTES-aligned.
REQ-005 SHALL have port uncoreclk  in  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port uncore_rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have AW inputs s_axi_awid/awaddr/awlen/awsize/awburst/awvalid (ID_WIDTH/ADDR_WIDTH/8/3/2/1) and output s_axi_awready (1).
REQ-008 SHALL have W inputs s_axi_wdata/wstrb/wlast/wvalid (64/8/1/1) and output s_axi_wready (1).
REQ-009 SHALL have B outputs s_axi_bid/bresp/bvalid (ID_WIDTH/2/1) and input s_axi_bready (1).
REQ-010 SHALL have AR inputs s_axi_arid/araddr/arlen/arsize/arburst/arvalid, widths as AW, and output s_axi_arready (1).
REQ-011 SHALL have R outputs s_axi_rid/rdata/rresp/rlast/rvalid (ID_WIDTH/64/2/1/1) and input s_axi_rready (1).
REQ-012 SHALL accept and ignore awlock/awcache/awprot/awqos and the AR equivalents (widths 1/4/3/4).

Function
REQ-013 Read and write paths SHALL be independent FSMs, each with one transaction outstanding; backing store one write port plus one read port.
REQ-014 Write FSM SHALL be W_IDLE -> W_DATA on AW handshake -> W_RESP on beat carrying WLAST -> W_IDLE on B handshake.
REQ-015 awready SHALL be high exactly in W_IDLE; wready exactly in W_DATA; bvalid exactly in W_RESP, rising the cycle after the WLAST handshake.
REQ-016 Each W handshake SHALL write only the byte lanes with wstrb set, at the current beat address, visible to reads the next cycle.
REQ-017 Beat address SHALL advance by 2^size: INCR linear, FIXED constant, WRAP within a (len+1)*2^size-aligned window.
REQ-018 Read FSM SHALL be R_IDLE -> R_FETCH on AR handshake -> R_DATA -> R_IDLE on R handshake of the last beat.
REQ-019 arready SHALL be high exactly in R_IDLE; AR handshake in cycle N SHALL give first rvalid in N+2.
REQ-020 With rready held high, beats SHALL be back-to-back, one per cycle; rdata/rid/rresp/rlast SHALL hold stable while rvalid && !rready.
REQ-021 rlast SHALL assert on beat index arlen; rid/bid SHALL equal the accepted arid/awid.
REQ-022 Response SHALL be DECERR (2'b11) when any beat address lies outside [BASE_ADDR, BASE_ADDR+MEM_BYTES): writes dropped, rdata zero for that beat.
REQ-023 Response SHALL be SLVERR (2'b10) for size > 3, burst 2'b11, or WRAP with len not in {1,3,7,15}; all beats still handshaken, no writes, rdata zero.
REQ-024 WLAST early (before beat awlen) SHALL end the burst with SLVERR; beats beyond awlen SHALL be dropped with wready kept high until WLAST, then SLVERR.
REQ-025 DECERR SHALL take precedence over SLVERR; otherwise OKAY (2'b00).
REQ-026 Same-cycle write and read to one address SHALL return the old data.

Reset
REQ-027 On uncore_rstn low, both FSMs SHALL enter IDLE immediately; awready=arready=1 and wready=bvalid=rvalid=rlast=0 after reset is removed.
REQ-028 bid, rid, bresp, rresp, rdata SHALL reset to zero; backing-store contents SHALL be unaffected by reset.
REQ-029 Reset mid-burst SHALL abandon the transaction with no B or R response.

Structure
REQ-030 A shared package SHALL hold the RESP_* codes (OKAY/EXOKAY/SLVERR/DECERR), BURST_* codes and the FSM state enums.
REQ-031 Beat-address generation (addr, size, len, burst -> next addr) SHALL be one sub-module, axi_burst_addr_gen, instantiated once per path.

Verification
REQ-032 AW INCR addr=0x100 len=3 size=3, four W beats all-strobe, then AR same -> BRESP=OKAY, four R beats matching data, rlast on beat 3, first rvalid 2 cycles after AR.
REQ-033 WRAP addr=0x118 len=3 size=3 read -> beat addresses 0x118,0x100,0x108,0x110.
REQ-034 Write wstrb=0x0F data=0xFFFF_FFFF_FFFF_FFFF over 0 -> readback 0x0000_0000_FFFF_FFFF.
REQ-035 AR addr=BASE_ADDR+MEM_BYTES len=0 -> one beat rresp=2'b11, rdata=0, rlast=1.
REQ-036 AW len=1 with WLAST on beat 2 (three beats) -> only beats 0-1 written, BRESP=2'b10.
REQ-037 rready random toggling during len=7 read, then reset asserted mid-burst -> stable R payload while stalled; after reset rvalid=0, arready=1.
